buzzer_tone_gen: RTL and testbench

// Consumes the selected note_out[3:0] and octave_out[1:0] from the mode controller.

---
 rtl/buzzer_tone_gen.sv | 159 +++++++++++++++
 tb/tb_buzzer_tone_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_tone_gen.sv
// ============================================================================
// Module   : buzzer_tone_gen
// Function : Square-wave buzzer driver with a silence gap on every pitch change.
// Revision : 1.0
// ============================================================================
`default_nettype none

module buzzer_tone_gen #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int GAP_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  output logic       speaker,
  output logic       playing
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  // Rounded half period for a frequency given in hundredths of a hertz.
  function automatic logic [18:0] calc_half(input longint f_centi);
    longint num;
    num       = longint'(CLK_HZ) * 64'sd100;
    calc_half = 19'((num + f_centi) / (64'sd2 * f_centi));
  endfunction

  localparam logic [18:0] HALF_DO = calc_half(64'sd26163);
  localparam logic [18:0] HALF_RE = calc_half(64'sd29366);
  localparam logic [18:0] HALF_MI = calc_half(64'sd32963);
  localparam logic [18:0] HALF_FA = calc_half(64'sd34923);
  localparam logic [18:0] HALF_SO = calc_half(64'sd39200);
  localparam logic [18:0] HALF_LA = calc_half(64'sd44000);
  localparam logic [18:0] HALF_SI = calc_half(64'sd49388);

  localparam logic [19:0] GAP_RELOAD = (GAP_CYCLES > 0) ? 20'(GAP_CYCLES - 1) : 20'd0;

  state_t      r_state,    w_state_nxt;
  logic        r_speaker,  w_speaker_nxt;
  logic        r_playing,  w_playing_nxt;
  logic [18:0] r_hc,       w_hc_nxt;
  logic [19:0] r_gc,       w_gc_nxt;
  logic [4:0]  r_cur_code, w_cur_code_nxt;
  logic [4:0]  w_code;
  logic [18:0] w_half_mid;
  logic [18:0] w_half;

  // Pitch code: {octave, note}; zero means silence.
  always_comb begin
    w_code = 5'd0;
    if (enable && (note_in != 4'd0) && (note_in <= 4'd7)) begin
      w_code = {((octave_in == 2'd3) ? 2'd1 : octave_in), note_in[2:0]};
    end
  end

  always_comb begin
    w_half_mid = 19'd0;
    case (r_cur_code[2:0])
      3'd1:    w_half_mid = HALF_DO;
      3'd2:    w_half_mid = HALF_RE;
      3'd3:    w_half_mid = HALF_MI;
      3'd4:    w_half_mid = HALF_FA;
      3'd5:    w_half_mid = HALF_SO;
      3'd6:    w_half_mid = HALF_LA;
      3'd7:    w_half_mid = HALF_SI;
      default: w_half_mid = 19'd0;
    endcase
  end

  always_comb begin
    w_half = w_half_mid;
    case (r_cur_code[4:3])
      2'd0:    w_half = {w_half_mid[17:0], 1'b0};
      2'd2:    w_half = {1'b0, w_half_mid[18:1]};
      default: w_half = w_half_mid;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_speaker_nxt  = r_speaker;
    w_playing_nxt  = r_playing;
    w_hc_nxt       = r_hc;
    w_gc_nxt       = r_gc;
    w_cur_code_nxt = r_cur_code;

    if (w_code == 5'd0) begin
      w_state_nxt    = S_IDLE;
      w_speaker_nxt  = 1'b0;
      w_playing_nxt  = 1'b0;
      w_hc_nxt       = 19'd0;
      w_cur_code_nxt = 5'd0;
    end else if ((r_state == S_IDLE) ||
                 ((r_state == S_PLAY) && (w_code != r_cur_code))) begin
      w_cur_code_nxt = w_code;
      w_speaker_nxt  = 1'b0;
      w_playing_nxt  = 1'b0;
      w_hc_nxt       = 19'd0;
      if (GAP_CYCLES > 0) begin
        w_state_nxt = S_GAP;
        w_gc_nxt    = GAP_RELOAD;
      end else begin
        w_state_nxt   = S_PLAY;
        w_speaker_nxt = 1'b1;
        w_playing_nxt = 1'b1;
      end
    end else if (r_state == S_GAP) begin
      if (w_code != r_cur_code) begin
        w_cur_code_nxt = w_code;
        w_gc_nxt       = GAP_RELOAD;
      end else if (r_gc == 20'd0) begin
        w_state_nxt   = S_PLAY;
        w_speaker_nxt = 1'b1;
        w_playing_nxt = 1'b1;
        w_hc_nxt      = 19'd0;
      end else begin
        w_gc_nxt = r_gc - 20'd1;
      end
    end else if (r_state == S_PLAY) begin
      // Same pitch held: keep phase running without any restart.
      if (r_hc == (w_half - 19'd1)) begin
        w_speaker_nxt = ~r_speaker;
        w_hc_nxt      = 19'd0;
      end else begin
        w_hc_nxt = r_hc + 19'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_speaker  <= 1'b0;
      r_playing  <= 1'b0;
      r_hc       <= 19'd0;
      r_gc       <= 20'd0;
      r_cur_code <= 5'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_speaker  <= w_speaker_nxt;
      r_playing  <= w_playing_nxt;
      r_hc       <= w_hc_nxt;
      r_gc       <= w_gc_nxt;
      r_cur_code <= w_cur_code_nxt;
    end
  end

  assign speaker = r_speaker;
  assign playing = r_playing;

endmodule

`default_nettype wire

// File: tb/tb_buzzer_tone_gen.sv
// ============================================================================
// Module   : tb_buzzer_tone_gen
// Function : Self-checking bench for buzzer_tone_gen at a scaled clock rate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_buzzer_tone_gen;

  localparam int CLK_HZ_TB = 200_000;
  localparam int GAP_TB    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] note_in;
  logic [1:0] octave_in;
  logic       spk, ply, spk0, ply0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  buzzer_tone_gen #(.CLK_HZ(CLK_HZ_TB), .GAP_CYCLES(GAP_TB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .note_in(note_in),
    .octave_in(octave_in), .speaker(spk), .playing(ply)
  );

  buzzer_tone_gen #(.CLK_HZ(CLK_HZ_TB), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .reset(reset), .enable(enable), .note_in(note_in),
    .octave_in(octave_in), .speaker(spk0), .playing(ply0)
  );

  // Reference pitch arithmetic straight from note frequencies.
  function automatic int half_of(input int code);
    real fr;
    int  mid;
    case (code % 8)
      1: fr = 261.63;
      2: fr = 293.66;
      3: fr = 329.63;
      4: fr = 349.23;
      5: fr = 392.00;
      6: fr = 440.00;
      default: fr = 493.88;
    endcase
    mid = $rtoi(CLK_HZ_TB / (2.0 * fr) + 0.5);
    case (code / 8)
      0: return mid * 2;
      2: return mid / 2;
      default: return mid;
    endcase
  endfunction

  function automatic int code_of(input logic en, input logic [3:0] n, input logic [1:0] o);
    if (!en || n == 4'd0 || n > 4'd7) return 0;
    return ((o == 2'd3) ? 1 : int'(o)) * 8 + int'(n);
  endfunction

  // Model: mode 0 silent, 1 gap, 2 playing; speaker derived from elapsed time.
  int     m_mode = 0;
  int     m_cur  = 0;
  longint cyc    = 0;
  longint m_gs   = 0;
  longint m_ps   = 0;

  always @(posedge clk) begin
    int c;
    cyc++;
    c = code_of(enable, note_in, octave_in);
    if (reset || c == 0) begin
      m_mode = 0;
      m_cur  = 0;
    end else if (m_mode == 0 || (m_mode == 2 && c != m_cur)) begin
      m_cur  = c;
      m_mode = 1;
      m_gs   = cyc;
    end else if (m_mode == 1) begin
      if (c != m_cur) begin
        m_cur = c;
        m_gs  = cyc;
      end else if (cyc - m_gs == GAP_TB) begin
        m_mode = 2;
        m_ps   = cyc;
      end
    end
  end

  function automatic logic exp_spk();
    if (m_mode != 2) return 1'b0;
    return (((cyc - m_ps) / half_of(m_cur)) % 2 == 0);
  endfunction

  task automatic apply(input logic en, input logic [3:0] n, input logic [1:0] o);
    enable    = en;
    note_in   = n;
    octave_in = o;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    repeat (5000) begin
      @(negedge clk);
      n++;
      if (spk === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic count_level(input logic lvl, output int n);
    n = 1;
    repeat (5000) begin
      @(negedge clk);
      if (spk !== lvl) return;
      n++;
    end
    n = -1;
  endtask

  task automatic test_reset();
    apply(1'b1, 4'd6, 2'd1);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_total++;
      if (spk !== 1'b0 || ply !== 1'b0)
        $display("FAIL reset_hold: speaker=%b playing=%b required 0/0", spk, ply);
      else n_pass++;
    end
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (spk !== 1'b0 || ply !== 1'b0)
      $display("FAIL reset_release: speaker=%b playing=%b required 0/0", spk, ply);
    else n_pass++;
  endtask

  task automatic test_a_mid();
    int n;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_rise(n);
    n_total++;
    if (n !== GAP_TB + 1) $display("FAIL a_mid_gap: rise after %0d edges, required %0d", n, GAP_TB + 1);
    else n_pass++;
    n_total++;
    if (ply !== 1'b1) $display("FAIL a_mid_playing: playing=%b required 1", ply);
    else n_pass++;
    count_level(1'b1, n);
    n_total++;
    if (n !== half_of(14)) $display("FAIL a_mid_high: %0d cycles, required %0d", n, half_of(14));
    else n_pass++;
    count_level(1'b0, n);
    n_total++;
    if (n !== half_of(14) || ply !== 1'b1)
      $display("FAIL a_mid_low: %0d cycles playing=%b, required %0d and 1", n, ply, half_of(14));
    else n_pass++;
  endtask

  task automatic test_octave();
    logic [1:0] octs [3] = '{2'd2, 2'd0, 2'd3};
    int n, h;
    foreach (octs[i]) begin
      apply(1'b1, 4'd6, octs[i]);
      wait_rise(n);
      count_level(1'b1, h);
      n_total++;
      if (n !== GAP_TB + 1 || h !== half_of(code_of(1'b1, 4'd6, octs[i])))
        $display("FAIL octave_%0d: rise %0d half %0d, required %0d and %0d",
                 octs[i], n, h, GAP_TB + 1, half_of(code_of(1'b1, 4'd6, octs[i])));
      else n_pass++;
    end
  endtask

  task automatic test_pitch_change();
    int n, h;
    count_level(1'b0, n);
    repeat (10) @(negedge clk);
    apply(1'b1, 4'd5, 2'd1);
    @(negedge clk);
    n_total++;
    if (spk !== 1'b0 || ply !== 1'b0)
      $display("FAIL pitch_change_cut: speaker=%b playing=%b required 0/0", spk, ply);
    else n_pass++;
    wait_rise(n);
    count_level(1'b1, h);
    n_total++;
    if (n !== GAP_TB || h !== half_of(13))
      $display("FAIL pitch_change_g: rise %0d half %0d, required %0d and %0d", n, h, GAP_TB, half_of(13));
    else n_pass++;
    apply(1'b1, 4'd4, 2'd1);
    repeat (2) @(negedge clk);
    apply(1'b1, 4'd3, 2'd1);
    wait_rise(n);
    count_level(1'b1, h);
    n_total++;
    if (n !== GAP_TB + 1 || h !== half_of(11))
      $display("FAIL gap_restart: rise %0d half %0d, required %0d and %0d", n, h, GAP_TB + 1, half_of(11));
    else n_pass++;
  endtask

  task automatic test_rest();
    int n, h;
    for (int v = 0; v < 3; v++) begin
      count_level(1'b0, n);
      repeat (5) @(negedge clk);
      case (v)
        0:       apply(1'b1, 4'd0, 2'd1);
        1:       apply(1'b1, 4'd9, 2'd1);
        default: apply(1'b0, 4'd3, 2'd1);
      endcase
      @(negedge clk);
      n_total++;
      if (spk !== 1'b0 || ply !== 1'b0)
        $display("FAIL rest_%0d: speaker=%b playing=%b required 0/0", v, spk, ply);
      else n_pass++;
      repeat (3) @(negedge clk);
      apply(1'b1, 4'd3, 2'd1);
      wait_rise(n);
      count_level(1'b1, h);
      n_total++;
      if (n !== GAP_TB + 1 || h !== half_of(11))
        $display("FAIL rest_replay_%0d: rise %0d half %0d, required %0d and %0d", v, n, h, GAP_TB + 1, half_of(11));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_play();
    int n;
    count_level(1'b0, n);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (spk !== 1'b0 || ply !== 1'b0 || spk0 !== 1'b0 || ply0 !== 1'b0)
      $display("FAIL reset_mid_play: outputs %b%b%b%b required 0000", spk, ply, spk0, ply0);
    else n_pass++;
  endtask

  task automatic test_gap0();
    int h;
    apply(1'b1, 4'd6, 2'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (spk0 !== 1'b1 || ply0 !== 1'b1)
      $display("FAIL gap0_first_edge: speaker=%b playing=%b required 1/1", spk0, ply0);
    else n_pass++;
    h = 1;
    repeat (5000) begin
      @(negedge clk);
      if (spk0 !== 1'b1) break;
      h++;
    end
    n_total++;
    if (h !== half_of(22)) $display("FAIL gap0_high: %0d cycles, required %0d", h, half_of(22));
    else n_pass++;
  endtask

  task automatic test_random();
    int hold, r;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 15);
      if (r < 11)       apply(1'b1, 4'($urandom_range(1, 7)), 2'($urandom_range(0, 3)));
      else if (r == 11) apply(1'b1, 4'd0, octave_in);
      else if (r == 12) apply(1'b1, 4'($urandom_range(8, 15)), octave_in);
      else if (r == 13) apply(1'b0, note_in, octave_in);
      else              apply(1'b1, note_in, 2'($urandom_range(0, 3)));
      reset = ($urandom_range(0, 30) == 0);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(20, 600);
      repeat (hold) begin
        @(negedge clk);
        reset = 1'b0;
        n_total++;
        if (spk !== exp_spk() || ply !== (m_mode == 2))
          $display("FAIL random_cycle_%0d: speaker=%b playing=%b required %b/%b",
                   cyc, spk, ply, exp_spk(), (m_mode == 2));
        else n_pass++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    apply(1'b0, 4'd0, 2'd0);
    @(negedge clk);
    test_reset();
    test_a_mid();
    test_octave();
    test_pitch_change();
    test_rest();
    test_reset_mid_play();
    test_gap0();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
